m_muldiv_unit: RTL
==================

// Module: m_muldiv_unit
// PURPOSE
//  Iterative integer multiply/divide unit, the multi-cycle companion to the single-cycle ALU.
//  Covers RV32M-style ops (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) at parametrised width.
//  Valid/ready handshake on both sides lets the processor stall while the unit is busy.
//  Radix-2 shift-add / restoring shift-subtract, one bit per clock.
// PARAMETERS
//  WIDTH  32  operand/result width in bits (>=4, even)
// PORTS
//  i_clk       in   1      clock, all state updates on posedge
//  i_reset_n   in   1      asynchronous, active-low reset
//  i_valid     in   1      request valid
//  o_ready     out  1      unit can accept a request (high only in IDLE)
//  i_op        in   3      0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//  i_a         in   WIDTH  operand a (multiplicand / dividend)
//  i_b         in   WIDTH  operand b (multiplier / divisor)
//  i_flush     in   1      synchronous abort of the operation in flight
//  o_valid     out  1      result valid, held until accepted
//  i_ready     in   1      consumer accepts result
//  o_result    out  WIDTH  result
//  o_dbz       out  1      flag: result came from divide-by-zero (qualifies o_valid)
// BEHAVIOUR
//  - Reset (i_reset_n=0, async): state=IDLE, o_ready=1, o_valid=0, o_result=0, o_dbz=0, counter=0.
//  - FSM IDLE -> BUSY -> FIXUP -> DONE -> IDLE.
//    IDLE: accept on edge where i_valid&o_ready; latch op, |a|,|b|, result signs; -> BUSY.
//    BUSY: one iteration per edge, counter 0..WIDTH-1; after WIDTH-th iteration -> FIXUP.
//    FIXUP: apply sign negation, select hi/lo half or quotient/remainder; -> DONE.
//    DONE: o_valid=1; on edge with i_ready=1 -> IDLE (o_ready high the next cycle).
//  - Latency: o_valid rises WIDTH+2 edges after the accepting edge (34 for WIDTH=32).
//  - Signedness: MUL/MULH/DIV/REM signed both; MULHSU a signed, b unsigned; *U unsigned both.
//  - Product is 2*WIDTH bits internally; MUL returns low half, MULH* return high half.
//  - Signed div: quotient rounds toward zero; remainder takes sign of dividend.
//  - Divide by zero (b==0): quotient = all ones, remainder = a, o_dbz=1; short-circuit:
//    IDLE -> DONE on accepting edge, o_valid after 1 edge.
//  - Signed overflow (DIV/REM, a=MIN, b=-1): quotient=MIN, remainder=0, o_dbz=0; short-circuit as above.
//  - Backpressure: in DONE with i_ready=0, o_result/o_dbz/o_valid held stable indefinitely.
//  - i_valid while not o_ready is ignored (no queuing); operands need not be held after acceptance.
//  - i_flush: from BUSY/FIXUP/DONE -> IDLE on next edge, o_valid=0, result discarded;
//    i_flush in IDLE wins over i_valid (no accept). Flush and i_ready same edge in DONE: IDLE, same outcome.
//  - Reset asserted mid-operation: immediate return to reset values; no partial result visible.
//  - o_result is registered; it changes only on the FIXUP->DONE or short-circuit edge.
// STRUCTURE
//  - Shared package/header (muldiv_defs.vh): op encodings, state encodings (2-bit), OP_IS_DIV/OP_IS_SIGNED_A/B macros.
//  - Sub-module m_muldiv_step: combinational single iteration (add-shift for mul,
//    compare-subtract-shift for div) on {acc, shreg} of 2*WIDTH bits; instantiated once.
//  - Top module holds FSM, counter ($clog2(WIDTH)+1 bits), operand/sign registers, fixup mux.
// TESTING (WIDTH=32)
//  - MUL a=7,b=-3 -> o_result=0xFFFFFFEB, o_valid 34 edges after accept, o_dbz=0.
//  - MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU -1*2 -> 0xFFFFFFFF.
//  - DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 0xFFFFFFFE/2 -> 0x7FFFFFFF.
//  - DIVU 5/0 -> 0xFFFFFFFF, o_dbz=1; REMU 5/0 -> 5; DIV 0x80000000/-1 -> 0x80000000, REM -> 0; all valid after 1 edge.
//  - Backpressure: hold i_ready=0 five cycles in DONE -> o_valid/o_result stable, o_ready=0, new i_valid ignored.
//  - Abort: i_flush at iteration 10 -> IDLE next edge, o_valid never rises; repeat with i_reset_n=0 -> immediate reset values.

Source files
------------

// File: rtl/m_muldiv_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op and state
// encodings plus operand-signedness helpers.
package m_muldiv_unit_pkg;

   typedef enum logic [2:0] {
      OP_MUL    = 3'd0,
      OP_MULH   = 3'd1,
      OP_MULHSU = 3'd2,
      OP_MULHU  = 3'd3,
      OP_DIV    = 3'd4,
      OP_DIVU   = 3'd5,
      OP_REM    = 3'd6,
      OP_REMU   = 3'd7
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BUSY  = 2'd1,
      ST_FIXUP = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   function automatic logic op_is_div(input op_e op);
      return op[2];
   endfunction

   function automatic logic op_is_rem(input op_e op);
      return op[2] & op[1];
   endfunction

   function automatic logic op_is_signed_a(input op_e op);
      return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
             (op == OP_DIV) || (op == OP_REM);
   endfunction

   function automatic logic op_is_signed_b(input op_e op);
      return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
   endfunction

endpackage

// File: rtl/m_muldiv_unit_if.sv
// Request/response handshake bundle between a processor and the muldiv unit.
interface m_muldiv_unit_if #(
   parameter int WIDTH = 32
) ();
   logic             i_valid;
   logic             o_ready;
   logic [2:0]       i_op;
   logic [WIDTH-1:0] i_a;
   logic [WIDTH-1:0] i_b;
   logic             i_flush;
   logic             o_valid;
   logic             i_ready;
   logic [WIDTH-1:0] o_result;
   logic             o_dbz;

   modport master (
      output i_valid, i_op, i_a, i_b, i_flush, i_ready,
      input  o_ready, o_valid, o_result, o_dbz
   );

   modport slave (
      input  i_valid, i_op, i_a, i_b, i_flush, i_ready,
      output o_ready, o_valid, o_result, o_dbz
   );
endinterface

// File: rtl/m_muldiv_unit_step.sv
// One radix-2 iteration on the {acc, shreg} pair: shift-add for multiply,
// compare-subtract-shift (restoring) for divide.
module m_muldiv_unit_step #(
   parameter int WIDTH = 32
) (
   input  logic             is_div,
   input  logic [WIDTH-1:0] acc,
   input  logic [WIDTH-1:0] shreg,
   input  logic [WIDTH-1:0] operand,
   output logic [WIDTH-1:0] acc_next,
   output logic [WIDTH-1:0] shreg_next
);
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   rem_trial;
   logic [WIDTH-1:0] diff;
   logic             fits;

   assign sum       = {1'b0, acc} + {1'b0, operand};
   assign rem_trial = {acc, shreg[WIDTH-1]};
   assign fits      = rem_trial >= {1'b0, operand};
   // When the divisor fits the trial remainder the difference is below 2^WIDTH.
   assign diff      = rem_trial[WIDTH-1:0] - operand;

   always_comb begin
      acc_next   = acc;
      shreg_next = shreg;
      if (is_div) begin
         if (fits) begin
            acc_next   = diff;
            shreg_next = {shreg[WIDTH-2:0], 1'b1};
         end else begin
            acc_next   = rem_trial[WIDTH-1:0];
            shreg_next = {shreg[WIDTH-2:0], 1'b0};
         end
      end else if (shreg[0]) begin
         {acc_next, shreg_next} = {sum, shreg[WIDTH-1:1]};
      end else begin
         {acc_next, shreg_next} = {1'b0, acc, shreg[WIDTH-1:1]};
      end
   end
endmodule

// File: rtl/m_muldiv_unit.sv
// Iterative RV32M-style multiply/divide unit: magnitude datapath, one bit per
// clock, with sign fixup and short-circuit for divide-by-zero / signed overflow.
module m_muldiv_unit
   import m_muldiv_unit_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic           i_clk,
   input  logic           i_reset_n,
   m_muldiv_unit_if.slave bus
);
   localparam int               CNT_W     = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);
   localparam logic [WIDTH-1:0] MIN_VAL   = {1'b1, {(WIDTH-1){1'b0}}};

   state_e           state_reg;
   op_e              op_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic [WIDTH-1:0] acc_reg;
   logic [WIDTH-1:0] shreg_reg;
   logic [WIDTH-1:0] operand_reg;
   logic             sign_res_reg;
   logic             sign_rem_reg;
   logic             ready_reg;
   logic             valid_reg;
   logic             dbz_reg;
   logic [WIDTH-1:0] result_reg;

   op_e              op_in;
   logic             neg_a;
   logic             neg_b;
   logic             b_zero;
   logic             div_ovf;
   logic [WIDTH-1:0] mag_a;
   logic [WIDTH-1:0] mag_b;
   logic [WIDTH-1:0] short_result;

   assign op_in   = op_e'(bus.i_op);
   assign neg_a   = op_is_signed_a(op_in) & bus.i_a[WIDTH-1];
   assign neg_b   = op_is_signed_b(op_in) & bus.i_b[WIDTH-1];
   assign mag_a   = neg_a ? ('0 - bus.i_a) : bus.i_a;
   assign mag_b   = neg_b ? ('0 - bus.i_b) : bus.i_b;
   assign b_zero  = op_is_div(op_in) && (bus.i_b == '0);
   assign div_ovf = op_is_div(op_in) && op_is_signed_a(op_in) &&
                    (bus.i_a == MIN_VAL) && (&bus.i_b);

   always_comb begin
      short_result = '1;
      if (b_zero) begin
         short_result = op_is_rem(op_in) ? bus.i_a : '1;
      end else begin
         short_result = op_is_rem(op_in) ? '0 : MIN_VAL;
      end
   end

   logic             is_div_op;
   logic [WIDTH-1:0] acc_step;
   logic [WIDTH-1:0] shreg_step;

   assign is_div_op = op_is_div(op_reg);

   m_muldiv_unit_step #(.WIDTH(WIDTH)) u_step (
      .is_div     (is_div_op),
      .acc        (acc_reg),
      .shreg      (shreg_reg),
      .operand    (operand_reg),
      .acc_next   (acc_step),
      .shreg_next (shreg_step)
   );

   // After the last iteration: product = {acc, shreg}; quotient = shreg, remainder = acc.
   logic [2*WIDTH-1:0] prod_mag;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quot_fix;
   logic [WIDTH-1:0]   rem_fix;
   logic [WIDTH-1:0]   fix_result;

   assign prod_mag = {acc_reg, shreg_reg};
   assign prod_fix = sign_res_reg ? ('0 - prod_mag) : prod_mag;
   assign quot_fix = sign_res_reg ? ('0 - shreg_reg) : shreg_reg;
   assign rem_fix  = sign_rem_reg ? ('0 - acc_reg) : acc_reg;

   always_comb begin
      fix_result = rem_fix;
      case (op_reg)
         OP_MUL:                       fix_result = prod_fix[WIDTH-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: fix_result = prod_fix[2*WIDTH-1:WIDTH];
         OP_DIV, OP_DIVU:              fix_result = quot_fix;
         default:                      fix_result = rem_fix;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_reg    <= ST_IDLE;
         op_reg       <= OP_MUL;
         cnt_reg      <= '0;
         acc_reg      <= '0;
         shreg_reg    <= '0;
         operand_reg  <= '0;
         sign_res_reg <= 1'b0;
         sign_rem_reg <= 1'b0;
         ready_reg    <= 1'b1;
         valid_reg    <= 1'b0;
         dbz_reg      <= 1'b0;
         result_reg   <= '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (bus.i_valid && !bus.i_flush) begin
                  op_reg       <= op_in;
                  sign_res_reg <= neg_a ^ neg_b;
                  sign_rem_reg <= neg_a;
                  acc_reg      <= '0;
                  cnt_reg      <= '0;
                  ready_reg    <= 1'b0;
                  if (op_is_div(op_in)) begin
                     shreg_reg   <= mag_a;
                     operand_reg <= mag_b;
                  end else begin
                     shreg_reg   <= mag_b;
                     operand_reg <= mag_a;
                  end
                  if (b_zero || div_ovf) begin
                     state_reg  <= ST_DONE;
                     result_reg <= short_result;
                     dbz_reg    <= b_zero;
                     valid_reg  <= 1'b1;
                  end else begin
                     state_reg <= ST_BUSY;
                  end
               end
            end
            ST_BUSY: begin
               if (bus.i_flush) begin
                  state_reg <= ST_IDLE;
                  ready_reg <= 1'b1;
                  cnt_reg   <= '0;
               end else begin
                  acc_reg   <= acc_step;
                  shreg_reg <= shreg_step;
                  if (cnt_reg == LAST_ITER) begin
                     cnt_reg   <= '0;
                     state_reg <= ST_FIXUP;
                  end else begin
                     cnt_reg <= cnt_reg + 1'b1;
                  end
               end
            end
            ST_FIXUP: begin
               if (bus.i_flush) begin
                  state_reg <= ST_IDLE;
                  ready_reg <= 1'b1;
               end else begin
                  result_reg <= fix_result;
                  dbz_reg    <= 1'b0;
                  valid_reg  <= 1'b1;
                  state_reg  <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (bus.i_flush || bus.i_ready) begin
                  state_reg <= ST_IDLE;
                  valid_reg <= 1'b0;
                  ready_reg <= 1'b1;
               end
            end
            default: begin
               state_reg <= ST_IDLE;
               ready_reg <= 1'b1;
               valid_reg <= 1'b0;
            end
         endcase
      end
   end

   assign bus.o_ready  = ready_reg;
   assign bus.o_valid  = valid_reg;
   assign bus.o_result = result_reg;
   assign bus.o_dbz    = dbz_reg;
endmodule
